// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the dual-lane load/store
//               sequencer.
//               - lsu_state_t      : sequencer FSM states
//               - lsu_req_t        : one lane's captured memory request
//                                    (default 32-bit view)
//               - LSU_TIMEOUT_DATA : load result returned when the memory
//                                    never answers
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int LSU_DW = 32;

    localparam logic [31:0] LSU_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_A  = 3'd1,
        WAIT_A = 3'd2,
        REQ_B  = 3'd3,
        WAIT_B = 3'd4,
        DONE   = 3'd5
    } lsu_state_t;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [LSU_DW-1:0] addr;
        logic [LSU_DW-1:0] wdata;
    } lsu_req_t;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_req_capture.sv
`default_nettype none
// ============================================================================
// Module      : lsu_req_capture
// Description : Holds one lane's memory request (valid, write, addr, wdata)
//               from the cycle the issue packet is accepted until the next
//               packet is accepted.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               cap_en_i        - load the request register this cycle
//               valid_i/write_i/addr_i/wdata_i - lane request from the pipe
//               valid_o/write_o/addr_o/wdata_o - registered request
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_req_capture #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_en_i,
    input  logic                  valid_i,
    input  logic                  write_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  valid_o,
    output logic                  write_o,
    output logic [DATA_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o
);

    logic                  valid_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cap_en_i) begin
            valid_q <= valid_i;
            write_q <= write_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    assign valid_o = valid_q;
    assign write_o = write_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule : lsu_req_capture
`default_nettype wire

// File: rtl/dual_lsu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dual_lsu_sequencer
// Description : Serialises the lane A and lane B memory operations of one
//               issue packet (A first) onto a single-ported data memory with
//               a req/ready/rvalid handshake. Stalls the pipeline while busy
//               and returns both load results together with a done pulse.
// Ports       : clk, rst                 - clock, async active-high reset
//               start, validA/B, writeA/B, addrA/B, wdataA/B
//                                        - issue packet from execute lanes
//               stall, done, err         - pipeline control / status
//               rdataA, rdataB           - load results (valid with done)
//               mem_req, mem_we, mem_addr, mem_wdata, mem_ready,
//               mem_rvalid, mem_rdata    - data memory handshake
// Revision    : 1.0 - initial release
// ============================================================================
module dual_lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  validA,
    input  logic                  writeA,
    input  logic [DATA_WIDTH-1:0] addrA,
    input  logic [DATA_WIDTH-1:0] wdataA,
    input  logic                  validB,
    input  logic                  writeB,
    input  logic [DATA_WIDTH-1:0] addrB,
    input  logic [DATA_WIDTH-1:0] wdataB,
    output logic                  stall,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdataA,
    output logic [DATA_WIDTH-1:0] rdataB,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic                  C_TO_EN   = (RESP_TIMEOUT != 0);
    localparam logic [31:0]           C_TO_LAST = 32'(RESP_TIMEOUT) - 32'd1;
    localparam logic [DATA_WIDTH-1:0] C_TO_DATA = DATA_WIDTH'(LSU_TIMEOUT_DATA);

    lsu_state_t            state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;

    logic                  w_capture;
    logic                  w_a_valid, w_a_write;
    logic [DATA_WIDTH-1:0] w_a_addr, w_a_wdata;
    logic                  w_b_valid, w_b_write;
    logic [DATA_WIDTH-1:0] w_b_addr, w_b_wdata;

    logic                  w_on_b;
    logic                  w_lane_valid, w_lane_write;
    logic [DATA_WIDTH-1:0] w_lane_addr, w_lane_wdata;
    logic                  w_timeout_hit;
    logic [DATA_WIDTH-1:0] w_resp_data;

    lsu_req_capture #(.DATA_WIDTH(DATA_WIDTH)) u_cap_a (
        .clk      (clk),
        .rst      (rst),
        .cap_en_i (w_capture),
        .valid_i  (validA),
        .write_i  (writeA),
        .addr_i   (addrA),
        .wdata_i  (wdataA),
        .valid_o  (w_a_valid),
        .write_o  (w_a_write),
        .addr_o   (w_a_addr),
        .wdata_o  (w_a_wdata)
    );

    lsu_req_capture #(.DATA_WIDTH(DATA_WIDTH)) u_cap_b (
        .clk      (clk),
        .rst      (rst),
        .cap_en_i (w_capture),
        .valid_i  (validB),
        .write_i  (writeB),
        .addr_i   (addrB),
        .wdata_i  (wdataB),
        .valid_o  (w_b_valid),
        .write_o  (w_b_write),
        .addr_o   (w_b_addr),
        .wdata_o  (w_b_wdata)
    );

    // Lane currently being served; REQ_x and WAIT_x share all datapath muxing.
    assign w_on_b       = (state_q == REQ_B) || (state_q == WAIT_B);
    assign w_lane_valid = w_on_b ? w_b_valid : w_a_valid;
    assign w_lane_write = w_on_b ? w_b_write : w_a_write;
    assign w_lane_addr  = w_on_b ? w_b_addr  : w_a_addr;
    assign w_lane_wdata = w_on_b ? w_b_wdata : w_a_wdata;

    // The wait counter starts at 0 on entry to WAIT_x, so the final wait cycle
    // is the one where the counter is about to reach RESP_TIMEOUT.
    assign w_timeout_hit = C_TO_EN && (cnt_q == C_TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        w_capture   = 1'b0;
        w_resp_data = mem_rdata;
        stall       = 1'b0;
        done        = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            IDLE: begin
                if (start && (validA || validB)) begin
                    w_capture = 1'b1;
                    // Combinational so the packet is frozen in its capture
                    // cycle; masked while reset holds every output low.
                    stall     = !rst;
                    rdata_a_d = '0;
                    rdata_b_d = '0;
                    state_d   = validA ? REQ_A : REQ_B;
                end
            end

            REQ_A, REQ_B: begin
                stall = 1'b1;
                // A lane is only entered when it was captured valid; the gate
                // keeps a stale capture from ever reaching the memory.
                mem_req   = w_lane_valid;
                mem_we    = w_lane_write;
                mem_addr  = w_lane_addr;
                mem_wdata = w_lane_wdata;
                if (mem_ready && w_lane_valid) begin
                    cnt_d   = '0;
                    state_d = w_on_b ? WAIT_B : WAIT_A;
                end
            end

            WAIT_A, WAIT_B: begin
                stall = 1'b1;
                if (mem_rvalid || w_timeout_hit) begin
                    // A real response wins over a timeout in the same cycle.
                    if (!mem_rvalid) begin
                        err_d       = 1'b1;
                        w_resp_data = C_TO_DATA;
                    end
                    // Stores leave the lane result at its cleared value of 0.
                    if (!w_lane_write) begin
                        if (w_on_b) begin
                            rdata_b_d = w_resp_data;
                        end else begin
                            rdata_a_d = w_resp_data;
                        end
                    end
                    state_d = (!w_on_b && w_b_valid) ? REQ_B : DONE;
                end else if (C_TO_EN) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign err    = err_q;
    assign rdataA = rdata_a_q;
    assign rdataB = rdata_b_q;

endmodule : dual_lsu_sequencer
`default_nettype wire

// File: tb/tb_dual_lsu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_lsu_sequencer
// Description : Directed self-checking bench for dual_lsu_sequencer with a
//               small behavioural single-port memory (ready from the bench,
//               rvalid one cycle after acceptance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_lsu_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        validA, writeA, validB, writeB;
    logic [31:0] addrA, wdataA, addrB, wdataB;
    logic        stall, done, err;
    logic [31:0] rdataA, rdataB;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    // memory model state
    logic [31:0] mem [logic [31:0]];
    logic        pend      = 1'b0;
    logic [31:0] pend_data = 32'h0;
    logic        rv_model  = 1'b0;
    logic [31:0] rd_model  = 32'h0;
    logic        hold_resp = 1'b0;
    logic        force_rv  = 1'b0;
    int          acc_count = 0;
    logic        log_we   [64];
    logic [31:0] log_addr [64];

    assign mem_rvalid = rv_model | force_rv;
    assign mem_rdata  = force_rv ? 32'hBAD0BAD0 : rd_model;

    dual_lsu_sequencer #(.DATA_WIDTH(32), .RESP_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .validA     (validA),
        .writeA     (writeA),
        .addrA      (addrA),
        .wdataA     (wdataA),
        .validB     (validB),
        .writeB     (writeB),
        .addrB      (addrB),
        .wdataB     (wdataB),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .rdataA     (rdataA),
        .rdataB     (rdataB),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acts mid-cycle: a request accepted in cycle k is answered with
    // rvalid high across the following posedge (the WAIT cycle).
    always @(negedge clk) begin
        if (pend) begin
            rv_model = 1'b1;
            rd_model = pend_data;
            pend     = 1'b0;
        end else begin
            rv_model = 1'b0;
            rd_model = 32'h0;
        end
        if (!rst && mem_req && mem_ready) begin
            if (acc_count < 64) begin
                log_we[acc_count]   = mem_we;
                log_addr[acc_count] = mem_addr;
            end
            acc_count++;
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                pend_data     = 32'h0;
            end else begin
                pend_data = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            end
            if (!hold_resp) pend = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_packet(input logic va, input logic wa, input logic [31:0] aa,
                                input logic [31:0] da, input logic vb, input logic wb,
                                input logic [31:0] ab, input logic [31:0] db);
        start = 1'b1;
        validA = va; writeA = wa; addrA = aa; wdataA = da;
        validB = vb; writeB = wb; addrB = ab; wdataB = db;
    endtask

    task automatic idle_inputs();
        start = 1'b0; validA = 1'b0; validB = 1'b0;
        writeA = 1'b0; writeB = 1'b0;
    endtask

    // Counts cycles after the start cycle until done; -1 if it never comes.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            #1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        step();
        #1;
        n_cmp++; if ({stall, done, err, mem_req, mem_we} !== 5'b0) begin n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {stall, done, err, mem_req, mem_we}); end
        n_cmp++; if ({rdataA, rdataB, mem_addr, mem_wdata} !== 128'h0) begin n_fail++;
            $display("FAIL reset_data: got %h %h %h %h expected all zero", rdataA, rdataB, mem_addr, mem_wdata); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_load_a();
        int lat;
        int base;
        base = acc_count;
        step();
        drive_packet(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++;
            $display("FAIL single_stall_capture: got %b expected 1", stall); end
        wait_done(lat);
        idle_inputs();
        n_cmp++; if (lat !== 3) begin n_fail++;
            $display("FAIL single_latency: got %0d expected 3", lat); end
        n_cmp++; if (rdataA !== 32'h12345678) begin n_fail++;
            $display("FAIL single_rdataA: got %h expected 12345678", rdataA); end
        n_cmp++; if (rdataB !== 32'h0) begin n_fail++;
            $display("FAIL single_rdataB: got %h expected 0", rdataB); end
        n_cmp++; if (acc_count != base + 1 || log_addr[base] !== 32'h100 || log_we[base] !== 1'b0) begin n_fail++;
            $display("FAIL single_access: got n=%0d addr=%h we=%b expected n=1 addr=100 we=0",
                     acc_count - base, log_addr[base], log_we[base]); end
        step();
        #1;
        n_cmp++; if (done !== 1'b0 || stall !== 1'b0) begin n_fail++;
            $display("FAIL single_done_pulse: got done=%b stall=%b expected 0 0", done, stall); end
    endtask

    task automatic test_b_only();
        int lat;
        int base;
        base = acc_count;
        step();
        drive_packet(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        wait_done(lat);
        idle_inputs();
        n_cmp++; if (lat !== 3) begin n_fail++;
            $display("FAIL bonly_latency: got %0d expected 3", lat); end
        n_cmp++; if (rdataB !== 32'h55) begin n_fail++;
            $display("FAIL bonly_rdataB: got %h expected 55", rdataB); end
        n_cmp++; if (rdataA !== 32'h0) begin n_fail++;
            $display("FAIL bonly_rdataA_cleared: got %h expected 0", rdataA); end
        n_cmp++; if (acc_count != base + 1 || log_addr[base] !== 32'h40) begin n_fail++;
            $display("FAIL bonly_access: got n=%0d addr=%h expected n=1 addr=40",
                     acc_count - base, log_addr[base]); end
    endtask

    task automatic test_no_op_start();
        int base;
        base = acc_count;
        step();
        drive_packet(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++;
            $display("FAIL noop_stall: got %b expected 0", stall); end
        step();
        #1;
        idle_inputs();
        n_cmp++; if (mem_req !== 1'b0 || done !== 1'b0 || acc_count != base) begin n_fail++;
            $display("FAIL noop_idle: got req=%b done=%b n=%0d expected 0 0 0", mem_req, done, acc_count - base); end
        n_cmp++; if (rdataB !== 32'h55) begin n_fail++;
            $display("FAIL noop_no_capture: got rdataB=%h expected 55", rdataB); end
    endtask

    task automatic test_store_then_load();
        int lat;
        int base;
        base = acc_count;
        step();
        drive_packet(1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 1'b1, 1'b0, 32'h200, 32'h0);
        wait_done(lat);
        idle_inputs();
        n_cmp++; if (lat !== 5) begin n_fail++;
            $display("FAIL dual_latency: got %0d expected 5", lat); end
        n_cmp++; if (rdataB !== 32'hCAFEF00D) begin n_fail++;
            $display("FAIL dual_rdataB: got %h expected cafef00d", rdataB); end
        n_cmp++; if (rdataA !== 32'h0) begin n_fail++;
            $display("FAIL dual_rdataA_store: got %h expected 0", rdataA); end
        n_cmp++; if (acc_count != base + 2 || log_we[base] !== 1'b1 || log_we[base+1] !== 1'b0
                     || log_addr[base] !== 32'h200 || log_addr[base+1] !== 32'h200) begin n_fail++;
            $display("FAIL dual_order: got n=%0d we=%b%b expected n=2 we=10 (write then read)",
                     acc_count - base, log_we[base], log_we[base+1]); end
    endtask

    task automatic test_backpressure();
        int lat;
        int base;
        base = acc_count;
        mem_ready = 1'b0;
        step();
        drive_packet(1'b1, 1'b1, 32'h300, 32'h11112222, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h300
                         || mem_wdata !== 32'h11112222 || stall !== 1'b1 || done !== 1'b0) begin n_fail++;
                $display("FAIL bp_hold_%0d: got req=%b we=%b addr=%h wdata=%h stall=%b expected 1 1 300 11112222 1",
                         i, mem_req, mem_we, mem_addr, mem_wdata, stall); end
        end
        step();
        mem_ready = 1'b1;
        wait_done(lat);
        idle_inputs();
        n_cmp++; if (lat !== 2) begin n_fail++;
            $display("FAIL bp_finish: got %0d cycles after ready expected 2", lat); end
        n_cmp++; if (acc_count != base + 1 || mem[32'h300] !== 32'h11112222) begin n_fail++;
            $display("FAIL bp_one_transfer: got n=%0d mem=%h expected n=1 mem=11112222",
                     acc_count - base, mem[32'h300]); end
    endtask

    task automatic test_timeout();
        hold_resp = 1'b1;
        step();
        drive_packet(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            step();
            #1;
            n_cmp++; if (err !== 1'b0 || done !== 1'b0) begin n_fail++;
                $display("FAIL to_early_%0d: got err=%b done=%b expected 0 0", c, err, done); end
        end
        step();
        #1;
        idle_inputs();
        n_cmp++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++;
            $display("FAIL to_done: got done=%b err=%b expected 1 1", done, err); end
        n_cmp++; if (rdataA !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL to_rdataA: got %h expected deadbeef", rdataA); end
        step();
        #1;
        hold_resp = 1'b0;
        n_cmp++; if (err !== 1'b1 || done !== 1'b0) begin n_fail++;
            $display("FAIL to_sticky: got err=%b done=%b expected 1 0", err, done); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        step();
        drive_packet(1'b1, 1'b0, 32'h600, 32'h0, 1'b1, 1'b0, 32'h604, 32'h0);
        step();
        step();
        step();
        hold_resp = 1'b1;
        #1;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h604) begin n_fail++;
            $display("FAIL rm_req_b: got req=%b addr=%h expected 1 604", mem_req, mem_addr); end
        step();
        #1;
        n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b1 || rdataA !== 32'hA6) begin n_fail++;
            $display("FAIL rm_wait_b: got req=%b stall=%b rdataA=%h expected 0 1 a6", mem_req, stall, rdataA); end
        rst = 1'b1;
        idle_inputs();
        #1;
        n_cmp++; if ({stall, done, err, mem_req} !== 4'b0 || rdataA !== 32'h0 || rdataB !== 32'h0) begin n_fail++;
            $display("FAIL rm_reset_now: got ctrl=%b rdataA=%h rdataB=%h expected 0000 0 0",
                     {stall, done, err, mem_req}, rdataA, rdataB); end
        step();
        step();
        rst = 1'b0;
        hold_resp = 1'b0;
        force_rv = 1'b1;
        step();
        force_rv = 1'b0;
        #1;
        n_cmp++; if ({stall, done, mem_req} !== 3'b0 || rdataB !== 32'h0 || rdataA !== 32'h0) begin n_fail++;
            $display("FAIL rm_late_rvalid: got ctrl=%b rdataA=%h rdataB=%h expected 000 0 0",
                     {stall, done, mem_req}, rdataA, rdataB); end
        step();
        drive_packet(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_done(lat);
        idle_inputs();
        n_cmp++; if (lat !== 3 || rdataA !== 32'h12345678 || err !== 1'b0) begin n_fail++;
            $display("FAIL rm_fresh: got lat=%0d rdataA=%h err=%b expected 3 12345678 0", lat, rdataA, err); end
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        addrA = 32'h0; wdataA = 32'h0; addrB = 32'h0; wdataB = 32'h0;
        idle_inputs();
        mem[32'h100] = 32'h12345678;
        mem[32'h40]  = 32'h55;
        mem[32'h600] = 32'hA6;
        mem[32'h604] = 32'hB6;

        test_reset();
        test_single_load_a();
        test_b_only();
        test_no_op_start();
        test_store_then_load();
        test_backpressure();
        test_timeout();
        test_reset_mid_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_dual_lsu_sequencer
`default_nettype wire

// File: doc/dual_lsu_sequencer.md
Name: dual_lsu_sequencer

Overview:
- Initiator-side load/store sequencer for the dual-issue datapath.
- Takes the lane A and lane B memory operations of one issue packet and serialises them, A first, onto a single-ported data memory with a req/ready/rvalid handshake.
- Stalls the pipeline while busy, then returns both load results together.
- Sits between the two execute-stage lanes and the data memory, in place of a direct dual-port hookup.

Parameters:
DATA_WIDTH, 32, width of addresses, write data and read data
RESP_TIMEOUT, 255, max cycles waited for rvalid before flagging error; 0 disables the timeout

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  issue packet presented this cycle; held by pipeline while stall=1
validA  input  1  lane A has a memory op
writeA  input  1  lane A op is a store (0 = load)
addrA  input  DATA_WIDTH  lane A byte address
wdataA  input  DATA_WIDTH  lane A store data
validB  input  1  lane B has a memory op
writeB  input  1  lane B op is a store (0 = load)
addrB  input  DATA_WIDTH  lane B byte address
wdataB  input  DATA_WIDTH  lane B store data
stall  output  1  freeze pipeline
done  output  1  one-cycle pulse; rdataA/B valid
err  output  1  sticky timeout flag; cleared only by rst
rdataA  output  DATA_WIDTH  lane A load result
rdataB  output  DATA_WIDTH  lane B load result
mem_req  output  1  memory request valid
mem_we  output  1  request is a write
mem_addr  output  DATA_WIDTH  request address
mem_wdata  output  DATA_WIDTH  request write data
mem_ready  input  1  memory accepts request this cycle
mem_rvalid  input  1  response: read data, or write ack
mem_rdata  input  DATA_WIDTH  read data

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; capture registers 0; rdataA/B=0.
- States: IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, DONE.
- IDLE:
  - start && (validA||validB): capture validA/B, writeA/B, addrA/B, wdataA/B.
  - Next state is REQ_A if validA, else REQ_B.
  - start with neither lane valid: no capture, stay IDLE, no stall.
- REQ_x:
  - mem_req=1; mem_we/addr/wdata come from the captured lane x.
  - On mem_ready=1, go to WAIT_x.
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 && !mem_ready.
- WAIT_x:
  - mem_req=0. On mem_rvalid=1:
    - a load latches mem_rdata into rdata_x;
    - a store latches nothing, and rdata_x=0.
  - Next state: WAIT_A goes to REQ_B if validB, else DONE. WAIT_B goes to DONE.
- DONE:
  - done=1 and stall=0 for exactly one cycle; next state IDLE.
  - rdataA/B hold their values until the next capture.
  - start is ignored in DONE, giving a one-cycle bubble between packets.
- stall = (state in REQ_A, WAIT_A, REQ_B, WAIT_B) OR (state==IDLE && start && (validA||validB)).
  - The IDLE term is combinational, so the packet is frozen in the same cycle it is captured.
- Ordering: one outstanding request; lane A is always fully completed before lane B is issued.
  - Stores to the same address leave B's data in memory.
  - Lane B reading an address that lane A just stored returns A's data.
- Latency with mem_ready=1 and rvalid one cycle after acceptance:
  - single op: capture, then REQ, WAIT, DONE → done 3 cycles after the start cycle;
  - dual op: done 5 cycles after the start cycle.
- Spurious mem_rvalid in IDLE, REQ_x or DONE is ignored.
- Timeout:
  - The WAIT_x counter counts from 0. If it reaches RESP_TIMEOUT without rvalid, set err.
  - The load result for that lane is 0xDEADBEEF; proceed as if the response had arrived.
- Reset mid-operation: immediate return to IDLE and mem_req drops. A late rvalid afterwards is ignored.
- Addresses pass through unmodified, with no alignment check. Accesses are full words only.

Decomposition:
- Shared package lsu_pkg:
  - typedef enum lsu_state_t {IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, DONE};
  - struct lsu_req_t {valid, write, addr, wdata};
  - constant LSU_TIMEOUT_DATA = 32'hDEADBEEF.
- One natural sub-module: lsu_req_capture, holding one lane's request register (instantiated twice).
- FSM, timeout counter and muxing stay in the top.

Test Plan:
- Single load A: validA=1, writeA=0, addrA=0x100; memory returns 0x12345678 one cycle after ready → mem_addr=0x100, mem_we=0; done 3 cycles after start; rdataA=0x12345678; rdataB=0.
- Dual store then load to the same address: A store 0x200←0xCAFEF00D, B load 0x200 → mem sees the write before the read; rdataB=0xCAFEF00D; done 5 cycles after start.
- Backpressure: mem_ready held 0 for 4 cycles in REQ_A → mem_req, mem_addr and mem_wdata stable throughout; stall=1 throughout; exactly one accepted transfer.
- B-only packet: validA=0, validB=1, load 0x40 returning 0x55 → FSM skips A; rdataB=0x55; done 3 cycles after start; rdataA=0.
- Timeout: RESP_TIMEOUT=4, no rvalid after a load request → err=1 after 4 wait cycles; rdataA=0xDEADBEEF; done still pulses; err stays 1 until rst.
- Reset mid-op: assert rst during WAIT_B, then later drive rvalid=1 → all outputs 0 immediately; late rvalid ignored; a fresh start afterwards is processed normally.
